conv3x3_sequencer: RTL and testbench
====================================

CONV3X3_SEQUENCER -- requirements
Module: conv3x3_sequencer

Interface
REQ-001 Parameter IMG_W, default 8: feature-map width in pixels; legal range 3..16.
REQ-002 Parameter IMG_H, default 8: feature-map height in pixels; legal range 3..16.
REQ-003 Parameter ADDR_W, default 8: pixel address width; IMG_W*IMG_H SHALL not exceed 2^ADDR_W.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request to convolve the whole map; sampled only in IDLE.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse when the final window result is accepted downstream.
REQ-009 rd_en  output  1  pixel/weight memory read strobe; memories return data one cycle later.
REQ-010 pix_addr  output  ADDR_W  pixel memory address, valid while rd_en=1.
REQ-011 wgt_addr  output  4  weight memory address (tap index 0..8), valid while rd_en=1.
REQ-012 mac_valid  output  1  multiplier/accumulator valid strobe; equals rd_en delayed one cycle.
REQ-013 acc_clr  output  1  one-cycle accumulator clear pulse, synchronising the accumulator's 9-count to the sequencer.
REQ-014 acc_out  input  8  running accumulator value from the accumulator.
REQ-015 out_valid  output  1  window result available.
REQ-016 out_ready  input  1  downstream accepts the result when out_valid=1 and out_ready=1.
REQ-017 out_data  output  8  captured 3x3 window sum.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, FLUSH, CAPTURE and OUT.
REQ-019 IDLE with start=1 -> ISSUE next cycle; row=0, col=0, tap=0; acc_clr=1 during that first ISSUE cycle only.
REQ-020 ISSUE: rd_en=1 for exactly 9 consecutive cycles, tap 0..8; wgt_addr=tap.
REQ-021 pix_addr SHALL equal (row + tap/3)*IMG_W + col + tap%3, using integer division and modulo.
REQ-022 After tap 8 -> FLUSH for 1 cycle (mac_valid for tap 8) -> CAPTURE for 1 cycle, in which acc_out is registered into out_data -> OUT.
REQ-023 Latency: first out_valid SHALL occur 11 cycles after the window's first rd_en cycle, i.e. 12 cycles after start is sampled.
REQ-024 OUT: out_valid=1 and out_data SHALL be held stable until handshake; no rd_en is issued while in OUT.
REQ-025 Handshake, not last window: col+1, or col=0 and row+1 when col=IMG_W-3; go to ISSUE next cycle with tap=0 and acc_clr=0.
REQ-026 Handshake on window (IMG_H-3, IMG_W-3): done=1 for 1 cycle, busy=0 and state=IDLE in the next cycle.
REQ-027 Window count SHALL be (IMG_W-2)*(IMG_H-2), visited in raster order.
REQ-028 start while busy SHALL be ignored; start coincident with done SHALL be ignored.
REQ-029 out_data is 8-bit modulo; the sequencer SHALL neither saturate nor flag overflow.
REQ-030 out_valid SHALL drop in the cycle after handshake.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, row=col=tap=0 and out_data=0, and drive busy, done, rd_en, mac_valid, acc_clr and out_valid to 0.
REQ-032 Reset mid-operation SHALL abandon the map; the next start SHALL restart at window (0,0) with acc_clr.

Verification
REQ-033 Reset held 3 cycles at any state -> all outputs 0; after release, outputs stay 0 until start.
REQ-034 IMG_W=IMG_H=8, all pixels=1, all weights=1, out_ready=1, pulse start -> 36 results each 9, first at start+12, one done pulse, busy low afterwards.
REQ-035 Address trace -> window 0 pix_addr 0,1,2,8,9,10,16,17,18; window 1 starts at 1; window 6 starts at 8; window 35 ends at 63.
REQ-036 out_ready=0 for 5 cycles on the first result -> out_valid=1 and out_data stable, rd_en=0; window 1 ISSUE begins the cycle after ready rises.
REQ-037 Pixels=255, weights=1 -> out_data=0xF7 (2295 mod 256); start pulsed during busy -> no restart and no extra done.
REQ-038 rst asserted during the 5th ISSUE cycle of window 3, then start -> pix_addr sequence restarts at 0 and acc_clr pulses.

Source files
------------

// File: rtl/conv3x3_sequencer.sv
// Sequencer for a 3x3 convolution: walks every window of an IMG_W x IMG_H map in raster
// order, issues 9 pixel/weight reads per window and hands the captured sum downstream.
module conv3x3_sequencer #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [3:0]        wgt_addr,
    output logic              mac_valid,
    output logic              acc_clr,
    input  logic [7:0]        acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [2:0]        dbg_state
);

    // Result handshake: a transfer happens on a rising edge where out_valid && out_ready;
    // once raised, out_valid and out_data hold unchanged until that transfer.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_FLUSH,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_row;
    logic [3:0]  r_col;
    logic [3:0]  r_tap;
    logic [1:0]  r_trow;
    logic [1:0]  r_tcol;
    logic        r_first;
    logic        r_mac_valid;
    logic [7:0]  r_out_data;

    logic              w_last_col;
    logic              w_last_win;
    logic              w_hs;
    logic [ADDR_W-1:0] w_addr;

    assign w_last_col = (r_col == 4'(IMG_W - 3));
    assign w_last_win = w_last_col && (r_row == 4'(IMG_H - 3));
    assign w_hs       = (r_state == S_OUT) && out_ready;

    // Tap row/column are tracked as separate counters so no divider is needed.
    assign w_addr = (ADDR_W'(r_row) + ADDR_W'(r_trow)) * ADDR_W'(IMG_W)
                  + ADDR_W'(r_col) + ADDR_W'(r_tcol);

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        rd_en     = 1'b0;
        acc_clr   = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        pix_addr  = '0;
        wgt_addr  = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                busy     = 1'b1;
                rd_en    = 1'b1;
                acc_clr  = r_first;
                pix_addr = w_addr;
                wgt_addr = r_tap;
                if (r_tap == 4'd8) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                busy   = 1'b1;
                w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy   = 1'b1;
                w_next = S_OUT;
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                done      = w_hs && w_last_win;
                if (out_ready) w_next = w_last_win ? S_IDLE : S_ISSUE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= 4'd0;
            r_col       <= 4'd0;
            r_tap       <= 4'd0;
            r_trow      <= 2'd0;
            r_tcol      <= 2'd0;
            r_first     <= 1'b0;
            r_mac_valid <= 1'b0;
            r_out_data  <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_mac_valid <= rd_en;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row   <= 4'd0;
                        r_col   <= 4'd0;
                        r_tap   <= 4'd0;
                        r_trow  <= 2'd0;
                        r_tcol  <= 2'd0;
                        r_first <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_first <= 1'b0;
                    if (r_tap == 4'd8) begin
                        r_tap  <= 4'd0;
                        r_trow <= 2'd0;
                        r_tcol <= 2'd0;
                    end else begin
                        r_tap <= r_tap + 4'd1;
                        if (r_tcol == 2'd2) begin
                            r_tcol <= 2'd0;
                            r_trow <= r_trow + 2'd1;
                        end else begin
                            r_tcol <= r_tcol + 2'd1;
                        end
                    end
                end
                S_CAPTURE: r_out_data <= acc_out;
                S_OUT: begin
                    if (out_ready) begin
                        if (w_last_win) begin
                            r_row <= 4'd0;
                            r_col <= 4'd0;
                        end else if (w_last_col) begin
                            r_col <= 4'd0;
                            r_row <= r_row + 4'd1;
                        end else begin
                            r_col <= r_col + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mac_valid = r_mac_valid;
    assign out_data  = r_out_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Bench for conv3x3_sequencer: models pixel/weight memories and the accumulator, and
// checks addresses, timing and window sums against a per-window arithmetic reference.
module tb_conv3x3_sequencer;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, rd_en, mac_valid, acc_clr, out_valid;
    logic [AW-1:0] pix_addr;
    logic [3:0]    wgt_addr;
    logic [7:0]    acc_out, out_data;
    logic [2:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pix_mem [0:255];
    logic [7:0] wgt_mem [0:15];
    logic [7:0] pd = 8'd0;
    logic [7:0] wd = 8'd0;
    logic [7:0] acc = 8'd0;
    int         acc_cnt = 0;

    always #5 clk = ~clk;

    conv3x3_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .pix_addr(pix_addr), .wgt_addr(wgt_addr),
        .mac_valid(mac_valid), .acc_clr(acc_clr), .acc_out(acc_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dbg_state(dbg_state)
    );

    // Memories answer one cycle after rd_en; accumulator restarts its sum every 9 MACs.
    always @(posedge clk) begin
        if (rd_en) begin
            pd <= pix_mem[pix_addr];
            wd <= wgt_mem[wgt_addr];
        end
        if (acc_clr) begin
            acc_cnt <= 0;
        end else if (mac_valid) begin
            acc     <= ((acc_cnt == 0) ? 8'd0 : acc) + pd * wd;
            acc_cnt <= (acc_cnt == 8) ? 0 : acc_cnt + 1;
        end
    end
    assign acc_out = acc;

    task automatic fill(input int mode);
        for (int i = 0; i < 256; i++)
            pix_mem[i] = (mode == 0) ? 8'd1 : (mode == 1) ? 8'd255 : 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++)
            wgt_mem[i] = (mode == 2) ? 8'($urandom_range(0, 255)) : 8'd1;
    endtask

    // ready_mode: 0 always ready, 1 stall first result 5 cycles, 2 random ready.
    task automatic run_map(input string tag, input int ready_mode, input bit poke);
        logic [AW-1:0] addr_q[$];
        logic [3:0]    tap_q[$];
        logic [7:0]    exp_q[$];
        logic [AW-1:0] ea;
        logic [3:0]    et;
        logic [7:0]    ed;
        logic [7:0]    held;
        int k, s, a, n_res, stall, first_ov;
        bit prev_rd, prev_hs, prev_last, prev_stall, fin, hs, last;

        for (int r = 0; r <= H - 3; r++) begin
            for (int c = 0; c <= W - 3; c++) begin
                s = 0;
                for (int t = 0; t < 9; t++) begin
                    a = (r + t / 3) * W + c + t % 3;
                    addr_q.push_back(AW'(a));
                    tap_q.push_back(4'(t));
                    s += int'(pix_mem[a]) * int'(wgt_mem[t]);
                end
                exp_q.push_back(8'(s));
            end
        end

        k = 0; n_res = 0; stall = 0; first_ov = -1; fin = 0;
        prev_rd = 0; prev_hs = 0; prev_last = 0; prev_stall = 0; held = 8'd0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b0;
        while (!fin && k < 3000) begin
            @(negedge clk);
            k++;
            start = poke;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) begin
                if (out_valid && n_res == 0 && stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                end else out_ready = 1'b1;
            end else out_ready = ($urandom_range(0, 9) < 6);
            #1;
            n_tests++;
            if (mac_valid !== prev_rd) begin
                n_fail++; $display("FAIL %s mac_valid k=%0d: got %b want %b", tag, k, mac_valid, prev_rd);
            end
            n_tests++;
            if (acc_clr !== (k == 1)) begin
                n_fail++; $display("FAIL %s acc_clr k=%0d: got %b want %b", tag, k, acc_clr, k == 1);
            end
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL %s busy k=%0d: got %b want 1", tag, k, busy);
            end
            if (rd_en === 1'b1) begin
                n_tests++;
                if (addr_q.size() == 0) begin
                    n_fail++; $display("FAIL %s extra_read k=%0d: got addr %0d want no read", tag, k, pix_addr);
                end else begin
                    ea = addr_q.pop_front();
                    et = tap_q.pop_front();
                    if (pix_addr !== ea || wgt_addr !== et) begin
                        n_fail++;
                        $display("FAIL %s addr k=%0d: got pix %0d wgt %0d want pix %0d wgt %0d",
                                 tag, k, pix_addr, wgt_addr, ea, et);
                    end
                end
            end
            if (prev_hs && !prev_last) begin
                n_tests++;
                if (out_valid !== 1'b0 || rd_en !== 1'b1) begin
                    n_fail++; $display("FAIL %s resume k=%0d: got valid %b rd %b want 0 1", tag, k, out_valid, rd_en);
                end
            end
            if (prev_stall) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== held || rd_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s hold k=%0d: got valid %b data %h rd %b want 1 %h 0",
                             tag, k, out_valid, out_data, rd_en, held);
                end
            end
            if (out_valid === 1'b1 && first_ov < 0) begin
                first_ov = k;
                n_tests++;
                if (k != 12) begin
                    n_fail++; $display("FAIL %s latency: got %0d want 12", tag, k);
                end
            end
            hs = (out_valid === 1'b1) && out_ready;
            last = 0;
            if (hs) begin
                n_res++;
                ed = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                last = (exp_q.size() == 0);
                n_tests++;
                if (out_data !== ed) begin
                    n_fail++; $display("FAIL %s data win=%0d: got %h want %h", tag, n_res - 1, out_data, ed);
                end
            end
            n_tests++;
            if (done !== (hs && last)) begin
                n_fail++; $display("FAIL %s done k=%0d: got %b want %b", tag, k, done, hs && last);
            end
            prev_rd    = rd_en;
            prev_hs    = hs;
            prev_last  = last;
            prev_stall = (out_valid === 1'b1) && !out_ready;
            held       = out_data;
            if (hs && last) fin = 1;
        end
        n_tests++;
        if (!fin) begin
            n_fail++; $display("FAIL %s timeout: got %0d results want %0d", tag, n_res, (W - 2) * (H - 2));
        end
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            n_tests++;
            if (busy !== 1'b0 || rd_en !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle_after: got busy %b rd %b valid %b done %b want 0", tag, busy, rd_en, out_valid, done);
            end
        end
        n_tests++;
        if (n_res != (W - 2) * (H - 2) || addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s count: got %0d results %0d reads left want %0d 0", tag, n_res, addr_q.size(), (W - 2) * (H - 2));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            n_tests++;
            if ({busy, done, rd_en, mac_valid, acc_clr, out_valid, out_data, pix_addr, wgt_addr} !== 26'd0) begin
                n_fail++; $display("FAIL reset_hold: got busy %b rd %b valid %b data %h want all 0", busy, rd_en, out_valid, out_data);
            end
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            n_tests++;
            if ({busy, done, rd_en, mac_valid, acc_clr, out_valid, out_data, pix_addr, wgt_addr} !== 26'd0) begin
                n_fail++; $display("FAIL reset_release: got busy %b rd %b valid %b data %h want all 0", busy, rd_en, out_valid, out_data);
            end
        end
    endtask

    task automatic test_all_ones();
        fill(0);
        run_map("ones", 0, 1'b0);
    endtask

    task automatic test_backpressure();
        fill(2);
        run_map("stall", 1, 1'b0);
    endtask

    task automatic test_overflow_and_start_ignored();
        fill(1);
        run_map("wrap", 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        fill(2);
        run_map("rand_ready", 2, 1'b0);
        run_map("rand_again", 2, 1'b1);
    endtask

    task automatic test_reset_mid();
        int nrd;
        bit hit;
        fill(2);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nrd = 0;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (rd_en === 1'b1) nrd++;
            if (nrd == 32) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (!hit || pix_addr !== 8'd12 || wgt_addr !== 4'd4) begin
            n_fail++; $display("FAIL mid_target: got hit %b pix %0d wgt %0d want 1 12 4", hit, pix_addr, wgt_addr);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, rd_en, mac_valid, acc_clr, out_valid, out_data, pix_addr, wgt_addr} !== 26'd0) begin
            n_fail++; $display("FAIL mid_async: got busy %b rd %b mac %b data %h want all 0", busy, rd_en, mac_valid, out_data);
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            n_tests++;
            if ({busy, done, rd_en, mac_valid, acc_clr, out_valid, out_data, pix_addr, wgt_addr} !== 26'd0) begin
                n_fail++; $display("FAIL mid_hold: got busy %b rd %b mac %b data %h want all 0", busy, rd_en, mac_valid, out_data);
            end
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            n_tests++;
            if ({busy, done, rd_en, mac_valid, acc_clr, out_valid, out_data, pix_addr, wgt_addr} !== 26'd0) begin
                n_fail++; $display("FAIL mid_release: got busy %b rd %b mac %b data %h want all 0", busy, rd_en, mac_valid, out_data);
            end
        end
        run_map("restart", 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_backpressure();
        test_overflow_and_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
